// File: rtl/hmm_pkg.sv
// Purpose : shared constants for the HMM sequence generator (LFSR, FSM encoding, widths).
// Latency : n/a (package).
// Backpressure: n/a (package).
package hmm_pkg;

  // Default model dimensions.
  localparam int HMM_N = 16;  // max sequence length
  localparam int HMM_I = 3;   // hidden states
  localparam int HMM_K = 3;   // observation symbols
  localparam int HMM_P = 16;  // random-draw width

  // Width helpers derived from the default dimensions.
  localparam int LEN_W   = $clog2(HMM_N + 1);
  localparam int STATE_W = $clog2(HMM_I);
  localparam int OBS_W   = $clog2(HMM_K);

  // Probability 1.0 in the P+1 bit CDF format.
  localparam logic [HMM_P:0] CDF_ONE = {1'b1, {HMM_P{1'b0}}};

  // Galois LFSR, right-shifting; taps x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_MASK  = 32'h8020_0003;
  localparam logic [31:0] LFSR_RESET = 32'h0000_0001;

  // FSM encoding.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_EMIT  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_TRANS = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // One LFSR step: shift right, fold the mask in when a 1 falls out.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

endpackage

// File: rtl/hmm_cdf_select.sv
// Purpose : picks the smallest index j with r < cdf[j]; falls back to the last index.
// Latency : combinational.
// Backpressure: none (pure function of its inputs).
// Ports   : cdf - M cumulative entries of P+1 bits; r - P-bit draw; sel - chosen index.
module hmm_cdf_select #(
  parameter int M = 3,
  parameter int P = 16,
  parameter int W = $clog2(M)
) (
  input  logic [M-1:0][P:0] cdf,
  input  logic [P-1:0]      r,
  output logic [W-1:0]      sel
);

  // Scan from the top down so the lowest qualifying index wins; no monotonicity
  // is assumed, so non-monotonic rows still resolve deterministically.
  always_comb begin
    sel = W'(M - 1);
    for (int j = M - 1; j >= 0; j--) begin
      if ({1'b0, r} < cdf[j]) sel = W'(j);
    end
  end

endmodule

// File: rtl/hmm_seq_gen.sv
// Purpose : samples an HMM hidden-state path and streams one observation per beat.
// Latency : first obs_valid 3 cycles after start; one beat per 3 cycles with obs_ready high.
// Backpressure: obs_out/state_out held while obs_valid && !obs_ready; LFSR only advances on draws.
// Ports   : clk, rst_n (async, active-low); start/length/seed_load/seed control;
//           cdfC/cdfA/cdfB model CDFs (must be stable while busy);
//           obs_out/obs_valid/obs_ready stream; state_out, path_true ground truth; busy, done status.
module hmm_seq_gen
  import hmm_pkg::*;
#(
  parameter int N = HMM_N,
  parameter int I = HMM_I,
  parameter int K = HMM_K,
  parameter int P = HMM_P
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [$clog2(N+1)-1:0]            length,
  input  logic                              seed_load,
  input  logic [31:0]                       seed,
  input  logic [I-1:0][P:0]                 cdfC,
  input  logic [I*I-1:0][P:0]               cdfA,
  input  logic [I*K-1:0][P:0]               cdfB,
  output logic [$clog2(K)-1:0]              obs_out,
  output logic                              obs_valid,
  input  logic                              obs_ready,
  output logic [$clog2(I)-1:0]              state_out,
  output logic [N-1:0][$clog2(I)-1:0]       path_true,
  output logic                              busy,
  output logic                              done
);

  localparam int LW = $clog2(N + 1);
  localparam int SW = $clog2(I);
  localparam int OW = $clog2(K);

  logic [2:0]        state;
  logic [31:0]       lfsr;
  logic [LW-1:0]     t;
  logic [LW-1:0]     len_q;
  logic [SW-1:0]     cur_s;

  logic [P-1:0]      r;
  logic              draw;
  logic [I-1:0][P:0] row_a;
  logic [K-1:0][P:0] row_b;
  logic [SW-1:0]     sel_c;
  logic [SW-1:0]     sel_a;
  logic [OW-1:0]     sel_b;

  assign r    = lfsr[P-1:0];
  assign draw = (state == ST_INIT) || (state == ST_EMIT) || (state == ST_TRANS);

  // Row mux: transition and emission rows for the current hidden state.
  always_comb begin
    row_a = '0;
    row_b = '0;
    for (int i = 0; i < I; i++) begin
      if (cur_s == SW'(i)) begin
        row_a = cdfA[i*I +: I];
        row_b = cdfB[i*K +: K];
      end
    end
  end

  hmm_cdf_select #(.M(I), .P(P), .W(SW)) u_sel_c (.cdf(cdfC),  .r(r), .sel(sel_c));
  hmm_cdf_select #(.M(I), .P(P), .W(SW)) u_sel_a (.cdf(row_a), .r(r), .sel(sel_a));
  hmm_cdf_select #(.M(K), .P(P), .W(OW)) u_sel_b (.cdf(row_b), .r(r), .sel(sel_b));

  // LFSR: seeded in IDLE only, stepped exactly once per draw so stalls in HOLD
  // never change the generated sequence. A zero seed would lock up, so use 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_RESET;
    end else if (state == ST_IDLE && seed_load) begin
      lfsr <= (seed == 32'd0) ? LFSR_RESET : seed;
    end else if (draw) begin
      lfsr <= lfsr_step(lfsr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      t         <= '0;
      len_q     <= '0;
      cur_s     <= '0;
      obs_out   <= '0;
      obs_valid <= 1'b0;
      state_out <= '0;
      path_true <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (length == '0) begin
              // Empty sequence: report completion without ever going busy.
              done <= 1'b1;
            end else begin
              len_q <= length;
              t     <= '0;
              busy  <= 1'b1;
              state <= ST_INIT;
            end
          end
        end
        ST_INIT: begin
          cur_s        <= sel_c;
          path_true[0] <= sel_c;
          state        <= ST_EMIT;
        end
        ST_EMIT: begin
          obs_out   <= sel_b;
          state_out <= cur_s;
          obs_valid <= 1'b1;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (obs_ready) begin
            obs_valid <= 1'b0;
            t         <= t + LW'(1);
            if (t == len_q - LW'(1)) begin
              // Registered here so the pulse is visible during the DONE cycle.
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_TRANS;
            end
          end
        end
        ST_TRANS: begin
          cur_s <= sel_a;
          // t was already incremented by the handshake that led here.
          for (int i = 0; i < N; i++) begin
            if (t == LW'(i)) path_true[i] <= sel_a;
          end
          state <= ST_EMIT;
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/hmm_seq_gen.md
Name: hmm_seq_gen

Overview:
- Hidden-Markov sequence generator: samples a hidden state path and an emitted observation stream from an HMM given as fixed-point cumulative distributions.
- Observations go out one per beat on a valid/ready stream for the Viterbi decoder, for loopback test and demo.
- The true state path is exported so decoded paths can be scored against ground truth.
- Randomness comes from an internal seedable 32-bit Galois LFSR.

Parameters:
- N, 16: max sequence length.
- I, 3: number of hidden states.
- K, 3: number of observation symbols.
- P, 16: random-draw width; CDF entries are P+1 bits unsigned, and 2^P means probability 1.0.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  pulse; begins a sequence when in IDLE.
- length  in  $clog2(N+1)  sequence length, 0..N; sampled on start.
- seed_load  in  1  loads seed into the LFSR; honoured in IDLE only.
- seed  in  32  LFSR seed; a value of 0 is replaced by 1.
- cdfC  in  [P:0] x I  initial-state CDF.
- cdfA  in  [P:0] x I*I  transition CDF; row i is cdfA[i*I+0..I-1].
- cdfB  in  [P:0] x I*K  emission CDF; row i is cdfB[i*K+0..K-1].
- obs_out  out  $clog2(K)  current observation.
- obs_valid  out  1  obs_out is valid.
- obs_ready  in  1  consumer accepts the beat.
- state_out  out  $clog2(I)  hidden state for the current beat.
- path_true  out  $clog2(I) x N  generated state path.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at end of sequence.

Behaviour:
- Reset values: all outputs 0 (obs_out, obs_valid, state_out, path_true[*], busy, done); LFSR = 32'h0000_0001; FSM in IDLE. Reset mid-sequence aborts immediately, and obs_valid drops asynchronously.
- LFSR: Galois, mask 32'h8020_0003, shifts right.
  - Every draw uses r = lfsr[P-1:0] of the current value, and the LFSR advances one step in the same cycle.
  - The LFSR advances only on draws, so backpressure never perturbs the sequence.
- Selection rule (row of I or K entries): result = smallest j with r < cdf[j]; if no entry qualifies, result = last index. This rule also defines behaviour for non-monotonic CDFs.
- Registers:
  - t: beat index, width $clog2(N+1).
  - cur_s: current hidden state.
  - len_q: length latched on start.
- FSM states and transitions:
  - IDLE
    - seed_load: lfsr <= (seed==0 ? 1 : seed).
    - start, len 0: next cycle done=1, stays IDLE, busy never rises.
    - start, len ≥1: len_q <= length, t <= 0, busy <= 1, go to INIT.
    - seed_load and start in the same cycle: seed applies first, start is accepted.
  - INIT (1 cycle): cur_s <= select(cdfC); path_true[0] <= that value; go to EMIT.
  - EMIT (1 cycle): obs_out <= select(cdfB row cur_s); state_out <= cur_s; obs_valid <= 1; go to HOLD.
  - HOLD
    - obs_out and state_out stay stable while obs_valid && !obs_ready.
    - On handshake: obs_valid <= 0 and t <= t+1.
    - If t == len_q-1: go to DONE.
    - Otherwise go to TRANS.
  - TRANS (1 cycle): cur_s <= select(cdfA row cur_s); path_true[t] <= that value (t already incremented); go to EMIT.
  - DONE (1 cycle): done=1, busy <= 0, go to IDLE.
- Latency and throughput:
  - First obs_valid rises 3 cycles after the start cycle.
  - With obs_ready held high, one beat is issued every 3 cycles.
  - done is asserted the cycle after the final handshake.
- Misc:
  - start is ignored outside IDLE.
  - seed_load is ignored outside IDLE.
  - CDF inputs must be held stable while busy is high; they are not latched.
  - path_true entries at index ≥ len_q keep their previous values.

Decomposition:
- hmm_pkg holds:
  - LFSR mask and reset value.
  - FSM state encoding (IDLE, INIT, EMIT, HOLD, TRANS, DONE).
  - Width helper constants derived from N, I, K.
  - CDF_ONE = 2^P.
- One sub-module: hmm_cdf_select #(M, P), combinational row search implementing the selection rule. It is instantiated three times: initial, transition and emission rows, with the row picked by a mux.

Test Plan:
1. Deterministic model, N=16, I=K=3, P=16, length=5, obs_ready=1:
   - cdfC={0,0x10000,0x10000}.
   - Transitions 0→1, 1→2, 2→0 (one-hot CDF rows).
   - Emission identity.
   - Expect obs 1,2,0,1,2 and path_true[0..4]=1,2,0,1,2; first obs_valid 3 cycles after start; done pulse 1 cycle after the 5th handshake.
2. Backpressure, seed 0xACE1, random CDFs, length=8; hold obs_ready low 10 cycles on beat 3.
   - obs_out and state_out stable throughout the stall.
   - Full obs sequence identical to a second run with the same seed and obs_ready=1.
3. length=0 → done pulse, obs_valid never high, busy stays 0. length=1 → exactly one beat, then done.
4. Statistics: seed 0xACE1, cdfC={0x5555,0xAAAA,0x10000}, 3000 runs of length 1 → each initial state count in 1000±100. seed=0 with seed_load → LFSR loads 1.
5. Control edges:
   - Assert rst_n low during HOLD of beat 2: obs_valid drops immediately; all outputs 0 after reset.
   - start pulsed while busy: ignored, sequence unchanged.
6. Loopback into the Viterbi decoder: near-deterministic model, length=12, obs_valid/obs_ready as glue. Decoded path equals path_true for all 12 entries.
